// File: rtl/status_led_seq.sv
// Status LED sequencer: mirrors the heartbeat, or flashes a latched fault code as N pulses plus a gap.
// Latency: led follows heartbeat one clk after it changes; burst phases are whole multiples of TICK_DIV.
// Backpressure: none; a new fault is only accepted in HB or at the end of a gap, others are dropped.
//
// Ports:
//   clk          system clock
//   rstn         synchronous active-low reset
//   heartbeat    slow square wave shown on the LED when no fault is latched
//   fault_valid  fault report strobe/level, qualified by fault_code != 0
//   fault_code   fault number 1..15 (0 = no fault)
//   fault_clr    clears the latched fault (only when LED_FAULT_LATCH_EN is defined)
//   led          status LED, active-high
//   fault_active high whenever a fault burst is being shown
//
// Build option LED_FAULT_LATCH_EN: bursts repeat until fault_clr instead of
// ending once the fault report goes away.
module status_led_seq #(
   parameter int TICK_DIV  = 50000,
   parameter int ON_TICKS  = 4,
   parameter int OFF_TICKS = 4,
   parameter int GAP_TICKS = 16
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       heartbeat,
   input  logic       fault_valid,
   input  logic [3:0] fault_code,
`ifdef LED_FAULT_LATCH_EN
   input  logic       fault_clr,
`endif
   output logic       led,
   output logic       fault_active
);

   localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
   localparam logic [7:0]  ON_LAST   = 8'(ON_TICKS - 1);
   localparam logic [7:0]  OFF_LAST  = 8'(OFF_TICKS - 1);
   localparam logic [7:0]  GAP_LAST  = 8'(GAP_TICKS - 1);

   typedef enum logic [1:0] {
      S_HB  = 2'd0,
      S_ON  = 2'd1,
      S_OFF = 2'd2,
      S_GAP = 2'd3
   } state_t;

   state_t      state, state_n;
   logic [15:0] presc, presc_n;
   logic [7:0]  phase, phase_n;
   logic [3:0]  pulse_cnt, pulse_cnt_n;
   logic [3:0]  code_q, code_n;
   logic        hb_q;
   logic        tick;
   logic        new_fault;

   assign tick      = (presc == TICK_LAST);
   assign new_fault = fault_valid && (fault_code != 4'd0);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= S_HB;
         presc     <= 16'd0;
         phase     <= 8'd0;
         pulse_cnt <= 4'd0;
         code_q    <= 4'd0;
         hb_q      <= 1'b0;
      end else begin
         state     <= state_n;
         presc     <= presc_n;
         phase     <= phase_n;
         pulse_cnt <= pulse_cnt_n;
         code_q    <= code_n;
         hb_q      <= heartbeat;
      end
   end

   always_comb begin
      state_n     = state;
      code_n      = code_q;
      pulse_cnt_n = pulse_cnt;

      case (state)
         S_HB: begin
            if (new_fault) begin
               code_n      = fault_code;
               pulse_cnt_n = 4'd1;
               state_n     = S_ON;
            end
         end
         S_ON: begin
            if (tick && (phase == ON_LAST)) begin
               state_n = S_OFF;
            end
         end
         S_OFF: begin
            if (tick && (phase == OFF_LAST)) begin
               if (pulse_cnt == code_q) begin
                  state_n = S_GAP;
               end else begin
                  // code_q <= 15 and we stop at equality, so this never wraps
                  pulse_cnt_n = pulse_cnt + 4'd1;
                  state_n     = S_ON;
               end
            end
         end
         S_GAP: begin
            if (tick && (phase == GAP_LAST)) begin
`ifdef LED_FAULT_LATCH_EN
               pulse_cnt_n = 4'd1;
               state_n     = S_ON;
`else
               if (new_fault) begin
                  code_n      = fault_code;
                  pulse_cnt_n = 4'd1;
                  state_n     = S_ON;
               end else begin
                  state_n = S_HB;
               end
`endif
            end
         end
         default: state_n = S_HB;
      endcase

`ifdef LED_FAULT_LATCH_EN
      // Clear overrides everything, including a fault arriving in HB
      if (fault_clr) begin
         state_n     = S_HB;
         code_n      = 4'd0;
         pulse_cnt_n = 4'd0;
      end
`endif
   end

   // Every transition restarts timing so each state lasts exactly N ticks.
   // All transitions change the state value, so a compare is sufficient.
   always_comb begin
      presc_n = 16'd0;
      phase_n = 8'd0;
      if (state_n == state) begin
         if (tick) begin
            presc_n = 16'd0;
            phase_n = phase + 8'd1;
         end else begin
            presc_n = presc + 16'd1;
            phase_n = phase;
         end
      end
   end

   always_comb begin
      led = 1'b0;
      case (state)
         S_HB:    led = hb_q;
         S_ON:    led = 1'b1;
         default: led = 1'b0;
      endcase
   end

   assign fault_active = (state != S_HB);

endmodule

// File: tb/tb_status_led_seq.sv
// Bench for status_led_seq: random and directed stimulus checked every cycle
// against a burst-timeline model, plus literal expectations for burst lengths,
// pulse counts, repeat period and reset behaviour.
module tb_status_led_seq;

   localparam int TD   = 4;
   localparam int ONT  = 2;
   localparam int OFFT = 2;
   localparam int GAPT = 4;
   localparam int P    = (ONT + OFFT) * TD;   // cycles per pulse slot

   logic       clk = 1'b0;
   logic       rstn;
   logic       heartbeat = 1'b0;
   logic       fault_valid;
   logic [3:0] fault_code;
`ifdef LED_FAULT_LATCH_EN
   logic       fault_clr = 1'b0;
`endif
   logic       led;
   logic       fault_active;

   int  errors = 0;
   int  checks = 0;
   bit  chk_en = 1'b0;
   bit  hb_rand = 1'b1;

   // model: active burst, its code, cycle offset within the burst, delayed heartbeat
   bit  m_active = 1'b0;
   int  m_code = 0;
   int  m_k = 0;
   bit  m_hbq = 1'b0;

   status_led_seq #(
      .TICK_DIV (TD),
      .ON_TICKS (ONT),
      .OFF_TICKS(OFFT),
      .GAP_TICKS(GAPT)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .heartbeat   (heartbeat),
      .fault_valid (fault_valid),
      .fault_code  (fault_code),
`ifdef LED_FAULT_LATCH_EN
      .fault_clr   (fault_clr),
`endif
      .led         (led),
      .fault_active(fault_active)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         if (errors <= 30)
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_led();
      if (!m_active) return int'(m_hbq);
      return int'((m_k < m_code * P) && ((m_k % P) < ONT * TD));
   endfunction

   // Reference model: a burst is a fixed timeline of code*P pulse cycles plus a gap
   always @(posedge clk) begin
      int  blen;
      bit  clr;
      bit  nf;
      clr = 1'b0;
`ifdef LED_FAULT_LATCH_EN
      clr = fault_clr;
`endif
      nf = fault_valid && (fault_code != 4'd0);
      if (!rstn) begin
         m_active = 1'b0; m_code = 0; m_k = 0; m_hbq = 1'b0;
      end else begin
         blen = m_code * P + GAPT * TD;
         if (clr) begin
            m_active = 1'b0; m_code = 0; m_k = 0;
         end else if (m_active) begin
            if (m_k == blen - 1) begin
               m_k = 0;
`ifndef LED_FAULT_LATCH_EN
               if (nf) m_code = int'(fault_code);
               else    m_active = 1'b0;
`endif
            end else begin
               m_k++;
            end
         end else if (nf) begin
            m_active = 1'b1; m_code = int'(fault_code); m_k = 0;
         end
         m_hbq = heartbeat;
      end
   end

   // Per-cycle compare against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("led_vs_model", int'(led), model_led());
         check("fault_active_vs_model", int'(fault_active), int'(m_active));
      end
   end

   always @(negedge clk) begin
      if (hb_rand && ($urandom_range(0, 3) == 0)) heartbeat = ~heartbeat;
   end

   task automatic quiet_hb();
      hb_rand = 1'b0;
      heartbeat = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // Strobe a code and measure the burst: fault_active cycles, led pulses, led-high cycles
   task automatic burst(input logic [3:0] code, input int strobe_at, input logic [3:0] strobe_code,
                        output int dur, output int pulses, output int high);
      bit prev;
      prev = 1'b0; dur = 0; pulses = 0; high = 0;
      fault_valid = 1'b1; fault_code = code;
      @(negedge clk);
      fault_valid = 1'b0;
      while (fault_active && dur < 2000) begin
         if (led && !prev) pulses++;
         if (led) high++;
         prev = led;
         if (dur == strobe_at) begin
            fault_valid = 1'b1; fault_code = strobe_code;
         end else begin
            fault_valid = 1'b0;
         end
         dur++;
         @(negedge clk);
      end
      fault_valid = 1'b0;
   endtask

   initial begin
      int dur, pulses, high, n;
      int rises[$];
      bit prev;
      rstn = 1'b0; fault_valid = 1'b0; fault_code = 4'd0;
      repeat (3) @(negedge clk);
      check("reset_led", int'(led), 0);
      check("reset_fault_active", int'(fault_active), 0);
      chk_en = 1'b1;
      rstn = 1'b1;

      // heartbeat only
      repeat (30) @(negedge clk);

      // zero code is ignored
      fault_valid = 1'b1; fault_code = 4'd0;
      @(negedge clk);
      fault_valid = 1'b0;
      check("zero_code_ignored", int'(fault_active), 0);

      quiet_hb();
`ifndef LED_FAULT_LATCH_EN
      burst(4'd3, -1, 4'd0, dur, pulses, high);
      check("code3_dur", dur, 64);
      check("code3_pulses", pulses, 3);
      check("code3_high", high, 24);

      burst(4'd5, 10, 4'd7, dur, pulses, high);
      check("code5_dur", dur, 96);
      check("code5_pulses", pulses, 5);

      // held code 2: bursts repeat every 48 cycles, end after the burst in which it drops
      fault_valid = 1'b1; fault_code = 4'd2;
      prev = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 100; i++) begin
         if (led && !prev) rises.push_back(i);
         prev = led;
         if (i != 99) @(negedge clk);
      end
      fault_valid = 1'b0;
      check("held_rise_count", rises.size(), 5);
      if (rises.size() >= 3) check("held_period", rises[2] - rises[0], 48);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (fault_active && n < 500);
      check("held_drop_cycles", n, 45);
`else
      fault_valid = 1'b1; fault_code = 4'd1;
      @(negedge clk);
      fault_valid = 1'b0;
      repeat (4) @(negedge clk);
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      check("clr_fault_active", int'(fault_active), 0);
      check("clr_led", int'(led), 0);
      fault_valid = 1'b1; fault_code = 4'd4; fault_clr = 1'b1;
      @(negedge clk);
      fault_valid = 1'b0; fault_clr = 1'b0;
      check("clr_beats_fault_in_hb", int'(fault_active), 0);
      // latched code keeps repeating past its first gap
      fault_valid = 1'b1; fault_code = 4'd1;
      @(negedge clk);
      fault_valid = 1'b0;
      repeat (40) @(negedge clk);
      check("latched_repeat", int'(fault_active), 1);
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
`endif

      // reset in the middle of ON
      fault_valid = 1'b1; fault_code = 4'd3;
      @(negedge clk);
      fault_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_on_led", int'(led), 1);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      check("rst_mid_on_led", int'(led), 0);
      check("rst_mid_on_fault_active", int'(fault_active), 0);

      // random traffic
      hb_rand = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         fault_valid = ($urandom_range(0, 19) == 0);
         fault_code  = 4'($urandom_range(0, 15));
         rstn        = ($urandom_range(0, 499) != 0);
`ifdef LED_FAULT_LATCH_EN
         fault_clr   = ($urandom_range(0, 99) == 0);
`endif
      end
      rstn = 1'b1; fault_valid = 1'b0;
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
